// File: rtl/dtree_pkg.sv
// Shared defaults and FSM state encoding for the decision-tree feature loader.
package dtree_pkg;

    localparam int N_FEAT_DEF  = 5;
    localparam int FEAT_W_DEF  = 8;
    localparam int CLASS_W_DEF = 5;
    localparam int CNT_W_DEF   = 16;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        DROP   = 2'd1,
        EVAL   = 2'd2,
        RESULT = 2'd3
    } state_e;

endpackage

// File: rtl/dtree_frame_fsm.sv
// Frame sequencer: tracks the byte index, detects short/long frames and owns both
// stream handshakes.
module dtree_frame_fsm
    import dtree_pkg::*;
#(
    parameter int N_FEAT = N_FEAT_DEF,
    parameter int IDX_W  = (N_FEAT > 1) ? $clog2(N_FEAT) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    input  logic             s_last,
    input  logic             m_ready,
    output logic             s_ready,
    output logic             m_valid,
    output logic             wr_en,
    output logic             eval_en,
    output logic             err,
    output logic [IDX_W-1:0] idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);

    state_e           state_r;
    state_e           state_nxt_s;
    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] idx_nxt_s;
    logic             s_ready_r;
    logic             m_valid_r;
    logic             xfer_s;
    logic             wr_en_s;
    logic             err_s;

    assign xfer_s = s_valid & s_ready_r;

    // Next-state, index and error decode.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        wr_en_s     = 1'b0;
        err_s       = 1'b0;
        case (state_r)
            LOAD: begin
                if (xfer_s) begin
                    wr_en_s = 1'b1;
                    if (s_last) begin
                        idx_nxt_s = '0;
                        if (idx_r == LAST_IDX) begin
                            state_nxt_s = EVAL;
                        end else begin
                            err_s = 1'b1;
                        end
                    end else if (idx_r == LAST_IDX) begin
                        err_s       = 1'b1;
                        idx_nxt_s   = '0;
                        state_nxt_s = DROP;
                    end else begin
                        idx_nxt_s = idx_r + IDX_W'(1);
                    end
                end else begin
                    idx_nxt_s = idx_r;
                end
            end
            DROP: begin
                if (xfer_s && s_last) begin
                    state_nxt_s = LOAD;
                    idx_nxt_s   = '0;
                end else begin
                    state_nxt_s = DROP;
                end
            end
            EVAL: begin
                state_nxt_s = RESULT;
            end
            RESULT: begin
                if (m_ready) begin
                    state_nxt_s = LOAD;
                    idx_nxt_s   = '0;
                end else begin
                    state_nxt_s = RESULT;
                end
            end
            default: begin
                state_nxt_s = LOAD;
                idx_nxt_s   = '0;
            end
        endcase
    end

    // State register; handshake flags are registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= LOAD;
            idx_r     <= '0;
            s_ready_r <= 1'b1;
            m_valid_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            idx_r     <= idx_nxt_s;
            s_ready_r <= (state_nxt_s == LOAD) || (state_nxt_s == DROP);
            m_valid_r <= (state_nxt_s == RESULT);
        end
    end

    assign s_ready = s_ready_r;
    assign m_valid = m_valid_r;
    assign wr_en   = wr_en_s;
    assign eval_en = (state_r == EVAL);
    assign err     = err_s;
    assign idx     = idx_r;

endmodule

// File: rtl/dtree_feature_loader.sv
// Byte-serial feature loader in front of a combinational decision tree: assembles a
// frame onto a parallel bus, samples the tree's class and returns it as a result stream.
module dtree_feature_loader
    import dtree_pkg::*;
#(
    parameter int N_FEAT  = N_FEAT_DEF,
    parameter int FEAT_W  = FEAT_W_DEF,
    parameter int CLASS_W = CLASS_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [FEAT_W-1:0]        s_data,
    input  logic                     s_last,
    output logic [N_FEAT*FEAT_W-1:0] feat_bus,
    input  logic [CLASS_W-1:0]       tree_class,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [CLASS_W-1:0]       m_class,
    output logic                     err_frame,
    output logic [CNT_W-1:0]         frame_cnt,
    output logic [CNT_W-1:0]         err_cnt
);

    localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;

    logic [IDX_W-1:0]         idx_s;
    logic                     wr_en_s;
    logic                     eval_s;
    logic                     err_s;
    logic [N_FEAT*FEAT_W-1:0] feat_r;
    logic [CLASS_W-1:0]       m_class_r;
    logic                     err_frame_r;
    logic [CNT_W-1:0]         frame_cnt_r;
    logic [CNT_W-1:0]         err_cnt_r;

    dtree_frame_fsm #(
        .N_FEAT (N_FEAT),
        .IDX_W  (IDX_W)
    ) u_fsm (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_last  (s_last),
        .m_ready (m_ready),
        .s_ready (s_ready),
        .m_valid (m_valid),
        .wr_en   (wr_en_s),
        .eval_en (eval_s),
        .err     (err_s),
        .idx     (idx_s)
    );

    // Feature bank: rejected bytes of malformed frames land here too but are never sampled.
    always_ff @(posedge clk) begin
        if (rst) begin
            feat_r <= '0;
        end else begin
            for (int i = 0; i < N_FEAT; i++) begin
                if (wr_en_s && (idx_s == IDX_W'(i))) begin
                    feat_r[i*FEAT_W +: FEAT_W] <= s_data;
                end
            end
        end
    end

    // Class capture, error pulse and saturating counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_class_r   <= '0;
            err_frame_r <= 1'b0;
            frame_cnt_r <= '0;
            err_cnt_r   <= '0;
        end else begin
            err_frame_r <= err_s;
            if (eval_s) begin
                m_class_r <= tree_class;
            end
            if (eval_s && !(&frame_cnt_r)) begin
                frame_cnt_r <= frame_cnt_r + CNT_W'(1);
            end
            if (err_s && !(&err_cnt_r)) begin
                err_cnt_r <= err_cnt_r + CNT_W'(1);
            end
        end
    end

    assign feat_bus  = feat_r;
    assign m_class   = m_class_r;
    assign err_frame = err_frame_r;
    assign frame_cnt = frame_cnt_r;
    assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_dtree_feature_loader.sv
// Directed bench for dtree_feature_loader: a reference tree drives tree_class and a
// scoreboard queue holds the class expected for every well-formed frame sent.
module tb_dtree_feature_loader;

    localparam int NF = 5;
    localparam int FW = 8;
    localparam int CW = 5;
    localparam int KW = 16;

    logic             clk     = 1'b0;
    logic             rst     = 1'b1;
    logic             s_valid = 1'b0;
    logic             s_last  = 1'b0;
    logic [FW-1:0]    s_data  = 8'h00;
    logic             m_ready = 1'b1;
    logic             s_ready;
    logic             m_valid;
    logic             err_frame;
    logic [NF*FW-1:0] feat_bus;
    logic [CW-1:0]    tree_class;
    logic [CW-1:0]    m_class;
    logic [KW-1:0]    frame_cnt;
    logic [KW-1:0]    err_cnt;

    int            n_pass     = 0;
    int            n_total    = 0;
    int            err_pulses = 0;
    logic [CW-1:0] sb[$];
    logic [7:0]    fb[7];

    dtree_feature_loader dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .feat_bus   (feat_bus),
        .tree_class (tree_class),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_class    (m_class),
        .err_frame  (err_frame),
        .frame_cnt  (frame_cnt),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    // Stand-in for a generated tree: a small order-sensitive decision on the features.
    function automatic logic [CW-1:0] tree_ref(input logic [NF*FW-1:0] bus);
        logic [7:0] f[NF];
        logic [7:0] t;
        for (int i = 0; i < NF; i++) f[i] = bus[i*FW +: FW];
        if (f[0] < f[4]) t = f[1] + 8'd3 * f[2];
        else             t = (f[3] ^ f[0]) + 8'd7;
        return t[CW-1:0];
    endfunction

    assign tree_class = tree_ref(feat_bus);

    function automatic logic [NF*FW-1:0] pack5();
        logic [NF*FW-1:0] b;
        for (int i = 0; i < NF; i++) b[i*FW +: FW] = fb[i];
        return b;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock: score a result handshake due at the coming edge, then move to the next negedge.
    task automatic step();
        logic [CW-1:0] e;
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 64'(m_class), 64'h1_0000);
            end else begin
                e = sb.pop_front();
                chk("result_class", 64'(m_class), 64'(e));
            end
        end
        @(negedge clk);
        if (err_frame === 1'b1) err_pulses++;
    endtask

    task automatic do_reset();
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        err_pulses = 0;
    endtask

    task automatic set_fb(input logic [7:0] a, b, c, d, e, f, g);
        fb[0] = a; fb[1] = b; fb[2] = c; fb[3] = d; fb[4] = e; fb[5] = f; fb[6] = g;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        logic done;
        done = 1'b0;
        s_valid = 1'b1; s_data = d; s_last = l;
        for (int t = 0; t < 40 && !done; t++) begin
            done = s_ready;
            step();
        end
        if (!done) chk("s_ready_timeout", 64'(s_ready), 64'd1);
    endtask

    task automatic send_frame(input int n, input logic good);
        if (good) sb.push_back(tree_ref(pack5()));
        for (int i = 0; i < n; i++) send_byte(fb[i], (i == n - 1) ? 1'b1 : 1'b0);
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic wait_result();
        for (int t = 0; t < 40 && sb.size() > 0; t++) step();
        chk("result_timeout", 64'(sb.size()), 64'd0);
    endtask

    task automatic wait_mvalid();
        for (int t = 0; t < 20 && m_valid !== 1'b1; t++) step();
        chk("m_valid_wait", 64'(m_valid), 64'd1);
    endtask

    initial begin
        // 1: reset state, nominal frame, latency
        do_reset();
        chk("rst_feat_bus", 64'(feat_bus), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_class", 64'(m_class), 64'd0);
        chk("rst_err_frame", 64'(err_frame), 64'd0);
        chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd1);
        set_fb(8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h00, 8'h00);
        send_frame(5, 1'b1);
        chk("eval_m_valid", 64'(m_valid), 64'd0);
        chk("eval_s_ready", 64'(s_ready), 64'd0);
        step();
        chk("lat_m_valid", 64'(m_valid), 64'd1);
        chk("t1_feat_bus", 64'(feat_bus), 64'h50_4030_2010);
        chk("t1_m_class", 64'(m_class), 64'(tree_ref(40'h50_4030_2010)));
        chk("t1_frame_cnt", 64'(frame_cnt), 64'd1);
        step();
        chk("t1_m_valid_drop", 64'(m_valid), 64'd0);
        chk("t1_s_ready_back", 64'(s_ready), 64'd1);
        chk("t1_drained", 64'(sb.size()), 64'd0);

        // 2: short frame then good frame
        do_reset();
        set_fb(8'h0A, 8'h0B, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h00);
        send_frame(3, 1'b0);
        chk("short_err_pulse", 64'(err_frame), 64'd1);
        step();
        chk("short_err_one_cycle", 64'(err_frame), 64'd0);
        chk("short_err_cnt", 64'(err_cnt), 64'd1);
        chk("short_no_result", 64'(m_valid), 64'd0);
        set_fb(8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h00, 8'h00);
        send_frame(5, 1'b1);
        wait_result();
        chk("short_next_frame_cnt", 64'(frame_cnt), 64'd1);
        chk("short_err_pulses", 64'(err_pulses), 64'd1);

        // 3: long frame then good frame
        do_reset();
        set_fb(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07);
        for (int i = 0; i < 5; i++) send_byte(fb[i], 1'b0);
        chk("long_err_at_5th", 64'(err_frame), 64'd1);
        chk("long_drop_ready", 64'(s_ready), 64'd1);
        send_byte(fb[5], 1'b0);
        send_byte(fb[6], 1'b1);
        s_valid = 1'b0; s_last = 1'b0;
        chk("long_feat_kept", 64'(feat_bus), 64'(pack5()));
        chk("long_err_cnt", 64'(err_cnt), 64'd1);
        chk("long_err_pulses", 64'(err_pulses), 64'd1);
        step();
        step();
        chk("long_no_result", 64'(m_valid), 64'd0);
        set_fb(8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hE4, 8'h00, 8'h00);
        send_frame(5, 1'b1);
        wait_result();
        chk("long_next_frame_cnt", 64'(frame_cnt), 64'd1);

        // 4: result backpressure with the next frame already offered
        do_reset();
        m_ready = 1'b0;
        set_fb(8'h3C, 8'h5A, 8'h6B, 8'h21, 8'h90, 8'h00, 8'h00);
        send_frame(5, 1'b1);
        wait_mvalid();
        set_fb(8'hF0, 8'h13, 8'h57, 8'h9B, 8'h08, 8'h00, 8'h00);
        s_valid = 1'b1; s_data = fb[0]; s_last = 1'b0;
        for (int c = 0; c < 10; c++) begin
            chk("bp_s_ready", 64'(s_ready), 64'd0);
            chk("bp_m_valid", 64'(m_valid), 64'd1);
            chk("bp_m_class", 64'(m_class), 64'(sb[0]));
            step();
        end
        m_ready = 1'b1;
        send_frame(5, 1'b1);
        wait_result();
        chk("bp_frame_cnt", 64'(frame_cnt), 64'd2);
        chk("bp_err_cnt", 64'(err_cnt), 64'd0);

        // 5: reset mid-frame and mid-result
        do_reset();
        set_fb(8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) send_byte(fb[i], 1'b0);
        rst = 1'b1; s_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_feat", 64'(feat_bus), 64'd0);
        chk("rst_mid_m_valid", 64'(m_valid), 64'd0);
        rst = 1'b0;
        m_ready = 1'b0;
        set_fb(8'h12, 8'h9C, 8'h4D, 8'h2E, 8'hC5, 8'h00, 8'h00);
        send_frame(5, 1'b1);
        wait_mvalid();
        chk("rst_res_frame_cnt", 64'(frame_cnt), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        sb.delete();
        chk("rst_res_m_valid", 64'(m_valid), 64'd0);
        chk("rst_res_m_class", 64'(m_class), 64'd0);
        chk("rst_res_frame_cnt0", 64'(frame_cnt), 64'd0);
        chk("rst_res_s_ready", 64'(s_ready), 64'd1);
        rst = 1'b0;
        m_ready = 1'b1;
        step();
        step();
        set_fb(8'h02, 8'h81, 8'h35, 8'h6F, 8'hFE, 8'h00, 8'h00);
        send_frame(5, 1'b1);
        wait_result();
        chk("rst_after_frame_cnt", 64'(frame_cnt), 64'd1);

        // 6: frame counter saturation
        do_reset();
        force dut.frame_cnt_r = 16'hFFFE;
        @(negedge clk);
        release dut.frame_cnt_r;
        @(negedge clk);
        chk("sat_preload", 64'(frame_cnt), 64'hFFFE);
        for (int k = 0; k < 3; k++) begin
            set_fb(8'(8'h20 + 8'(k)), 8'h44, 8'(8'h19 * 8'(k)), 8'h61, 8'h7F, 8'h00, 8'h00);
            send_frame(5, 1'b1);
            wait_result();
            chk("sat_frame_cnt", 64'(frame_cnt), 64'hFFFF);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

endmodule
